// File: rtl/GPU_Shader_pkg.sv
// Shared shader-core package: the data word type, data-memory geometry and
// the writeback stage's state enum and entry payload.
package GPU_Shader_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned MEM_DEPTH    = 256;
    localparam int unsigned MEM_AW       = $clog2(MEM_DEPTH);
    localparam int unsigned WB_NUM_REGS  = 8;
    localparam int unsigned WB_REG_IDX_W = $clog2(WB_NUM_REGS);

    typedef enum logic [1:0] {
        WB_EMPTY = 2'd0,
        WB_WRITE = 2'd1,
        WB_WAIT  = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [WB_REG_IDX_W-1:0] dst;
        logic                    reg_we;
        word_t                   reg_data;
        logic                    mem_we;
        logic [MEM_AW-1:0]       mem_addr;
        word_t                   mem_data;
    } wb_entry_t;

endpackage

// File: rtl/shader_writeback.sv
// Writeback/commit stage following the ALU. It holds one entry, pulses the
// register-file write for one cycle, runs the store req/ack handshake and
// counts retired entries.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        ALU result handshake (in_ready is combinational)
//   in_*                     ALU result fields captured on accept
//   rf_we/rf_waddr/rf_wdata  register-file write port
//   mem_req/mem_addr/mem_wdata/mem_ack  store request handshake
//   fwd_valid/fwd_idx/fwd_data          bypass view of the pending reg write
//   retire_count             retired-entry counter, wraps modulo 2^32
module shader_writeback
    import GPU_Shader_pkg::*;
#(
    parameter int unsigned NUM_REGS = WB_NUM_REGS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [$clog2(NUM_REGS)-1:0]  in_dst,
    input  logic                         in_reg_write_en,
    input  logic [31:0]                  in_reg_write_data,
    input  logic                         in_mem_write_en,
    input  logic [MEM_AW-1:0]            in_mem_write_addr,
    input  logic [31:0]                  in_mem_write_data,
    output logic                         rf_we,
    output logic [$clog2(NUM_REGS)-1:0]  rf_waddr,
    output logic [31:0]                  rf_wdata,
    output logic                         mem_req,
    output logic [MEM_AW-1:0]            mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic                         mem_ack,
    output logic                         fwd_valid,
    output logic [$clog2(NUM_REGS)-1:0]  fwd_idx,
    output logic [31:0]                  fwd_data,
    output logic [31:0]                  retire_count
);

    localparam int unsigned REG_IDX_W = $clog2(NUM_REGS);

    wb_state_t   state_q, state_d;
    wb_entry_t   entry_q, entry_d;
    logic [31:0] count_q, count_d;
    logic        retire_c;
    logic        accept_c;

    // State, stage register and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WB_EMPTY;
            entry_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end

    // Retire / accept decision and next-state logic.
    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        count_d  = count_q;
        retire_c = 1'b0;
        in_ready = 1'b0;

        unique case (state_q)
            WB_EMPTY: in_ready = 1'b1;
            WB_WRITE: retire_c = !entry_q.mem_we || mem_ack;
            WB_WAIT:  retire_c = mem_ack;
            default:  in_ready = 1'b1;
        endcase

        if (retire_c) begin
            in_ready = 1'b1;
            count_d  = count_q + 32'd1;
        end

        accept_c = in_valid && in_ready;

        if (accept_c) begin
            state_d          = WB_WRITE;
            entry_d.dst      = WB_REG_IDX_W'(in_dst);
            entry_d.reg_we   = in_reg_write_en;
            entry_d.reg_data = in_reg_write_data;
            entry_d.mem_we   = in_mem_write_en;
            entry_d.mem_addr = in_mem_write_addr;
            entry_d.mem_data = in_mem_write_data;
        end else if (retire_c) begin
            // Clearing the entry keeps every data output at zero while empty.
            state_d = WB_EMPTY;
            entry_d = '0;
        end else if (state_q == WB_WRITE) begin
            state_d = WB_WAIT;
        end
    end

    // Output decode from the registered state and entry.
    always_comb begin
        rf_we        = (state_q == WB_WRITE) && entry_q.reg_we;
        rf_waddr     = REG_IDX_W'(entry_q.dst);
        rf_wdata     = entry_q.reg_data;
        mem_req      = ((state_q == WB_WRITE) && entry_q.mem_we) || (state_q == WB_WAIT);
        mem_addr     = entry_q.mem_addr;
        mem_wdata    = entry_q.mem_data;
        fwd_valid    = (state_q != WB_EMPTY) && entry_q.reg_we;
        fwd_idx      = fwd_valid ? REG_IDX_W'(entry_q.dst) : '0;
        fwd_data     = fwd_valid ? entry_q.reg_data : 32'd0;
        retire_count = count_q;
    end

endmodule

// File: tb/tb_shader_writeback.sv
// Directed bench for shader_writeback with hand-computed expectations.
module tb_shader_writeback;
    import GPU_Shader_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_dst;
    logic        in_reg_write_en;
    logic [31:0] in_reg_write_data;
    logic        in_mem_write_en;
    logic [7:0]  in_mem_write_addr;
    logic [31:0] in_mem_write_data;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        fwd_valid;
    logic [2:0]  fwd_idx;
    logic [31:0] fwd_data;
    logic [31:0] retire_count;

    int compared   = 0;
    int mismatched = 0;

    shader_writeback #(.NUM_REGS(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_dst            (in_dst),
        .in_reg_write_en   (in_reg_write_en),
        .in_reg_write_data (in_reg_write_data),
        .in_mem_write_en   (in_mem_write_en),
        .in_mem_write_addr (in_mem_write_addr),
        .in_mem_write_data (in_mem_write_data),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_ack           (mem_ack),
        .fwd_valid         (fwd_valid),
        .fwd_idx           (fwd_idx),
        .fwd_data          (fwd_data),
        .retire_count      (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
            $error("%s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] dst, input logic rwe,
                         input logic [31:0] rdata, input logic mwe,
                         input logic [7:0] maddr, input logic [31:0] mdata);
        in_valid          = v;
        in_dst            = dst;
        in_reg_write_en   = rwe;
        in_reg_write_data = rdata;
        in_mem_write_en   = mwe;
        in_mem_write_addr = maddr;
        in_mem_write_data = mdata;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        mem_ack = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_count", retire_count, 32'd0);

        // Single register write
        drive(1'b1, 3'd3, 1'b1, 32'h1234_5678, 1'b0, 8'd0, 32'd0);
        tick();
        idle();
        chk("rw_rf_we", 32'(rf_we), 32'd1);
        chk("rw_waddr", 32'(rf_waddr), 32'd3);
        chk("rw_wdata", rf_wdata, 32'h1234_5678);
        chk("rw_fwd_valid", 32'(fwd_valid), 32'd1);
        chk("rw_fwd_idx", 32'(fwd_idx), 32'd3);
        chk("rw_fwd_data", fwd_data, 32'h1234_5678);
        chk("rw_mem_req", 32'(mem_req), 32'd0);
        tick();
        chk("rw_rf_we_off", 32'(rf_we), 32'd0);
        chk("rw_count", retire_count, 32'd1);
        chk("rw_fwd_off", 32'(fwd_valid), 32'd0);

        // Back-to-back register writes, dst 0..3
        drive(1'b1, 3'd0, 1'b1, 32'hA0, 1'b0, 8'd0, 32'd0);
        chk("b2b_ready0", 32'(in_ready), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_rf_we%0d", i), 32'(rf_we), 32'd1);
            chk($sformatf("b2b_waddr%0d", i), 32'(rf_waddr), 32'(i));
            chk($sformatf("b2b_wdata%0d", i), rf_wdata, 32'hA0 + 32'(i));
            if (i < 3) drive(1'b1, 3'(i + 1), 1'b1, 32'hA0 + 32'(i + 1), 1'b0, 8'd0, 32'd0);
            else       idle();
            chk($sformatf("b2b_ready%0d", i + 1), 32'(in_ready), 32'd1);
            tick();
        end
        chk("b2b_rf_we_off", 32'(rf_we), 32'd0);
        chk("b2b_count", retire_count, 32'd5);

        // Store with ack in the third request cycle
        drive(1'b1, 3'd1, 1'b0, 32'd0, 1'b1, 8'h05, 32'hDEAD_BEEF);
        tick();
        idle();
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("st_req%0d", c), 32'(mem_req), 32'd1);
            chk($sformatf("st_addr%0d", c), 32'(mem_addr), 32'h05);
            chk($sformatf("st_data%0d", c), mem_wdata, 32'hDEAD_BEEF);
            chk($sformatf("st_rf_we%0d", c), 32'(rf_we), 32'd0);
            chk($sformatf("st_ready%0d", c), 32'(in_ready), 32'd0);
            tick();
        end
        mem_ack = 1'b1;
        drive(1'b1, 3'd2, 1'b1, 32'h55, 1'b0, 8'd0, 32'd0);
        chk("st_req2", 32'(mem_req), 32'd1);
        chk("st_addr2", 32'(mem_addr), 32'h05);
        chk("st_ready_ack", 32'(in_ready), 32'd1);
        chk("st_count_pre", retire_count, 32'd5);
        tick();
        mem_ack = 1'b0;
        idle();
        chk("st_next_rf_we", 32'(rf_we), 32'd1);
        chk("st_next_waddr", 32'(rf_waddr), 32'd2);
        chk("st_next_wdata", rf_wdata, 32'h55);
        chk("st_next_mem_req", 32'(mem_req), 32'd0);
        chk("st_count", retire_count, 32'd6);
        tick();
        chk("st_count2", retire_count, 32'd7);

        // Store acked in its WRITE cycle, then a spurious ack while empty
        drive(1'b1, 3'd0, 1'b0, 32'd0, 1'b1, 8'h09, 32'h0BAD_F00D);
        tick();
        idle();
        mem_ack = 1'b1;
        #1;
        chk("imm_req", 32'(mem_req), 32'd1);
        chk("imm_addr", 32'(mem_addr), 32'h09);
        chk("imm_ready", 32'(in_ready), 32'd1);
        tick();
        chk("imm_req_off", 32'(mem_req), 32'd0);
        chk("imm_count", retire_count, 32'd8);
        chk("imm_addr_empty", 32'(mem_addr), 32'd0);
        tick();
        chk("spur_count", retire_count, 32'd8);
        mem_ack = 1'b0;

        // NOP entry
        drive(1'b1, 3'd4, 1'b0, 32'h99, 1'b0, 8'h33, 32'h77);
        tick();
        idle();
        chk("nop_rf_we", 32'(rf_we), 32'd0);
        chk("nop_mem_req", 32'(mem_req), 32'd0);
        chk("nop_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("nop_fwd_data", fwd_data, 32'd0);
        chk("nop_ready", 32'(in_ready), 32'd1);
        tick();
        chk("nop_count", retire_count, 32'd9);

        // Reset while a store waits for its ack
        drive(1'b1, 3'd0, 1'b0, 32'd0, 1'b1, 8'h07, 32'h77);
        tick();
        idle();
        tick();
        chk("rw8_req", 32'(mem_req), 32'd1);
        chk("rw8_addr", 32'(mem_addr), 32'h07);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rstw_req", 32'(mem_req), 32'd0);
        chk("rstw_ready", 32'(in_ready), 32'd1);
        chk("rstw_count", retire_count, 32'd0);
        chk("rstw_addr", 32'(mem_addr), 32'd0);
        chk("rstw_wdata", mem_wdata, 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rstw_late_ack", retire_count, 32'd0);
        chk("rstw_late_req", 32'(mem_req), 32'd0);

        // Counter wrap: preload the counter just below the wrap point
        dut.count_q = 32'hFFFF_FFFF;
        drive(1'b1, 3'd0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0);
        tick();
        idle();
        chk("wrap_pre", retire_count, 32'hFFFF_FFFF);
        tick();
        chk("wrap_post", retire_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shader_writeback.md
Name: shader_writeback

Overview:
- Writeback/commit stage directly downstream of the combinational ALU.
- Captures one ALU result per handshake into a single-entry stage register.
- Commits register-file writes as a one-cycle pulse and issues STORE requests to data memory with a req/ack handshake, back-pressuring the issue stage while a store is outstanding.
- Exports a bypass (forwarding) view of the pending register write and a retired-instruction counter.

Parameters:
- NUM_REGS, 8, number of architectural registers; REG_IDX_W = $clog2(NUM_REGS).
- MEM_AW, $clog2(MEM_DEPTH), data-memory address width; MEM_DEPTH comes from GPU_Shader_pkg.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ALU result valid this cycle
- in_ready  out  1  stage can accept this cycle
- in_dst  in  REG_IDX_W  destination register index from the instruction dst field
- in_reg_write_en  in  1  ALU reg_write_en
- in_reg_write_data  in  32 (word_t)  ALU reg_write_data
- in_mem_write_en  in  1  ALU mem_write_en
- in_mem_write_addr  in  MEM_AW  ALU mem_write_addr
- in_mem_write_data  in  32 (word_t)  ALU mem_write_data
- rf_we  out  1  register-file write strobe
- rf_waddr  out  REG_IDX_W  register-file write index
- rf_wdata  out  32  register-file write data
- mem_req  out  1  store request, held until acknowledged
- mem_addr  out  MEM_AW  store address
- mem_wdata  out  32  store data
- mem_ack  in  1  memory accepted the store this cycle
- fwd_valid  out  1  stage holds a pending register write
- fwd_idx  out  REG_IDX_W  its destination index
- fwd_data  out  32  its data
- retire_count  out  32  number of retired entries, wraps modulo 2^32

Behaviour:
- Accept: a transfer occurs at a rising edge when in_valid && in_ready. All in_* fields are captured into the stage register; the FSM enters WRITE.
- FSM states: EMPTY, WRITE, WAIT.
- EMPTY
  - in_ready = 1; all strobes low.
- WRITE (exactly one cycle per entry)
  - rf_we = stored reg_write_en.
  - mem_req = stored mem_write_en.
  - The entry retires this cycle if !mem_write_en, or if mem_write_en && mem_ack.
  - Otherwise the next state is WAIT.
- WAIT
  - rf_we = 0, so the register write is never repeated.
  - mem_req = 1; mem_addr and mem_wdata are held stable.
  - The entry retires in the cycle mem_ack = 1.
- Retire cycle
  - in_ready = 1 (combinational path from mem_ack to in_ready is permitted).
  - If in_valid is also high, the new entry loads and the state is WRITE next cycle (back-to-back, no bubble).
  - Otherwise the state is EMPTY.
  - retire_count increments by 1.
- Not retiring in WRITE/WAIT: in_ready = 0.
- Entry with both enables clear (NOP/unknown opcode): spends one WRITE cycle with no strobes, then retires and counts.
- Entry with both enables set: rf_we pulses in the first WRITE cycle; the store proceeds in parallel; the entry retires on mem_ack.
- Latency: accepted at edge N → rf_we/mem_req high in cycle N+1. Reg-only throughput is 1 entry/cycle.
- rf_waddr/rf_wdata and mem_addr/mem_wdata are driven from the stage register (registered, glitch-free). They are 0 in EMPTY.
- Forwarding outputs:
  - fwd_valid = state != EMPTY && stored reg_write_en.
  - fwd_idx/fwd_data = stored values; all 0 when fwd_valid = 0.
- mem_ack while mem_req = 0: ignored. Ack is sampled only in WRITE/WAIT with mem_write_en.
- Register index 0 is not special; it is written like any other.
- Reset (any state, including WAIT mid-store) → next edge:
  - state EMPTY; all stage fields 0; retire_count 0.
  - rf_we, mem_req, fwd_valid, mem_addr, mem_wdata, rf_waddr, rf_wdata, fwd_idx, fwd_data all 0; in_ready 1.
  - The outstanding store is abandoned. mem_ack and in_valid are ignored while rst = 1.
- retire_count wraps 0xFFFF_FFFF → 0x0000_0000 without a flag.

Decomposition:
- Shared package (GPU_Shader_pkg) gets:
  - wb_state_t enum {WB_EMPTY, WB_WRITE, WB_WAIT}.
  - wb_entry_t packed struct {dst, reg_we, reg_data, mem_we, mem_addr, mem_data}.
- Reused from the package: word_t, MEM_DEPTH.
- No sub-module is warranted. The single-entry register and 3-state FSM live in one module.

Test Plan:
- Reg write: after reset, in_valid=1, dst=3, reg_we=1, data=0x1234_5678 → next cycle rf_we=1, rf_waddr=3, rf_wdata=0x1234_5678, fwd_valid=1; following cycle rf_we=0, retire_count=1.
- Back-to-back: 4 reg writes on consecutive cycles (dst 0..3, data 0xA0..0xA3) → rf_we high 4 consecutive cycles with matching idx/data, in_ready constantly 1, retire_count=4.
- Store with delayed ack: mem_we=1, addr=0x05, data=0xDEAD_BEEF, ack after 3 cycles → mem_req high 3 cycles with addr/data stable, in_ready=0 until the ack cycle, a second valid input is accepted exactly in the ack cycle, rf_we never asserted.
- Store with immediate ack in the WRITE cycle → mem_req for 1 cycle, retire same cycle; spurious mem_ack while EMPTY → no effect on retire_count.
- NOP entry (both enables 0) → no rf_we, no mem_req, fwd_valid=0, retire_count increments by 1.
- Reset in WAIT (store addr 0x07 pending) → next cycle mem_req=0, in_ready=1, retire_count=0; a later mem_ack is ignored. retire_count forced near 0xFFFF_FFFF and incremented → wraps to 0.
